// File: rtl/forward_scoreboard_if.sv
// EXE-stage hazard lookup bus: instruction-side request fields and per-operand
// forward/stall responses.
interface forward_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_W   = 5,
  parameter int SEL_W   = $clog2(DEPTH+1)
);
  logic                       exe_valid;
  logic                       exe_wr;
  logic [REG_W-1:0]           exe_dst;
  logic [SEL_W-1:0]           exe_rdy_stage;
  logic [NUM_SRC*REG_W-1:0]   exe_src;
  logic                       advance;
  logic                       bubble;
  logic                       flush;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic [NUM_SRC-1:0]         src_stall;
  logic                       stall;

  modport master (
    output exe_valid, exe_wr, exe_dst, exe_rdy_stage, exe_src,
    output advance, bubble, flush,
    input  fwd_sel, src_stall, stall
  );

  modport slave (
    input  exe_valid, exe_wr, exe_dst, exe_rdy_stage, exe_src,
    input  advance, bubble, flush,
    output fwd_sel, src_stall, stall
  );
endinterface

// File: rtl/forward_scoreboard.sv
// Forwarding / load-use hazard scoreboard: tracks in-flight writes in stages
// 1..DEPTH and picks the youngest producer per EXE operand.
module fwd_lookup #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int SEL_W = 2
) (
  input  logic [DEPTH-1:0]            i_valid,
  input  logic [DEPTH-1:0][REG_W-1:0] i_dst,
  input  logic [DEPTH-1:0][SEL_W-1:0] i_rdy,
  input  logic [REG_W-1:0]            i_src,
  output logic [SEL_W-1:0]            o_sel,
  output logic                        o_stall
);
  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    o_sel   = '0;
    o_stall = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (i_valid[k-1] && (i_dst[k-1] == i_src) && (i_src != '0)) begin
        o_sel   = SEL_W'(k);
        o_stall = (SEL_W'(k) < i_rdy[k-1]);
      end
    end
  end
endmodule

module forward_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int REG_W   = 5,
  parameter int SEL_W   = $clog2(DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  forward_scoreboard_if.slave  bus
);
  logic [DEPTH-1:0]               r_valid;
  logic [DEPTH-1:0][REG_W-1:0]    r_dst;
  logic [DEPTH-1:0][SEL_W-1:0]    r_rdy;

  logic [SEL_W-1:0]               w_rdy_clamp;
  logic                           w_ins_valid;
  logic [NUM_SRC-1:0][SEL_W-1:0]  w_sel;
  logic [NUM_SRC-1:0]             w_stall;

  always_comb begin
    w_rdy_clamp = bus.exe_rdy_stage;
    if (bus.exe_rdy_stage == '0)
      w_rdy_clamp = SEL_W'(1);
    else if (bus.exe_rdy_stage > SEL_W'(DEPTH))
      w_rdy_clamp = SEL_W'(DEPTH);
  end

  assign w_ins_valid = bus.exe_valid & bus.exe_wr & (bus.exe_dst != '0);

  // Index k-1 holds stage k; bubble shifts in an empty stage-1 entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dst   <= '0;
      r_rdy   <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (bus.advance || bus.bubble) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_dst[k]   <= r_dst[k-1];
        r_rdy[k]   <= r_rdy[k-1];
      end
      r_valid[0] <= bus.advance & w_ins_valid;
      r_dst[0]   <= bus.exe_dst;
      r_rdy[0]   <= w_rdy_clamp;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_lookup #(.DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W)) u_lk (
      .i_valid (r_valid),
      .i_dst   (r_dst),
      .i_rdy   (r_rdy),
      .i_src   (bus.exe_src[g*REG_W +: REG_W]),
      .o_sel   (w_sel[g]),
      .o_stall (w_stall[g])
    );
  end

  assign bus.fwd_sel   = w_sel;
  assign bus.src_stall = w_stall;
  assign bus.stall     = |w_stall;
endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: queue-based producer model checked
// every cycle, plus literal expectations at key points.
module tb_forward_scoreboard;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int REG_W   = 5;
  localparam int SEL_W   = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  forward_scoreboard_if #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W)) bus ();

  forward_scoreboard #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: list of in-flight producers, youngest first, always DEPTH long.
  typedef struct { bit v; int d; int r; } ent_t;
  ent_t q[$];
  bit   known = 0;

  always @(posedge clk) begin
    ent_t e;
    if (rst) begin
      q.delete();
      for (int k = 0; k < DEPTH; k++) q.push_back('{0, 0, 1});
      known = 1;
    end else if (known) begin
      if (bus.flush) begin
        foreach (q[k]) q[k].v = 0;
      end else if (bus.advance || bus.bubble) begin
        e.v = bus.advance && bus.exe_valid && bus.exe_wr && (bus.exe_dst != 0);
        e.d = int'(bus.exe_dst);
        e.r = (bus.exe_rdy_stage == 0) ? 1 :
              (int'(bus.exe_rdy_stage) > DEPTH) ? DEPTH : int'(bus.exe_rdy_stage);
        q.push_front(e);
        void'(q.pop_back());
      end
    end
  end

  function automatic void model_op(input int src, output int sel, output bit st);
    sel = 0;
    st  = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (q[k].v && q[k].d == src && src != 0) begin
        sel = k + 1;
        st  = (k + 1) < q[k].r;
        break;
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [NUM_SRC*SEL_W-1:0] esel;
    logic [NUM_SRC-1:0]       est;
    int s; bit b;
    if (known) begin
      esel = '0;
      est  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        model_op(int'(bus.exe_src[i*REG_W +: REG_W]), s, b);
        esel[i*SEL_W +: SEL_W] = SEL_W'(s);
        est[i] = b;
      end
      total += 3;
      if (bus.fwd_sel !== esel) begin
        bad++;
        $display("FAIL model_fwd_sel t=%0t got=%b exp=%b", $time, bus.fwd_sel, esel);
      end
      if (bus.src_stall !== est) begin
        bad++;
        $display("FAIL model_src_stall t=%0t got=%b exp=%b", $time, bus.src_stall, est);
      end
      if (bus.stall !== (|est)) begin
        bad++;
        $display("FAIL model_stall t=%0t got=%b exp=%b", $time, bus.stall, |est);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk3(input string name, input int sel, input int sst, input int stl);
    chk({name, "_sel"},   int'(bus.fwd_sel),   sel);
    chk({name, "_sst"},   int'(bus.src_stall), sst);
    chk({name, "_stall"}, int'(bus.stall),     stl);
  endtask

  task automatic cyc(input bit adv, input bit bub, input bit fl,
                     input bit v, input bit wr, input int dst, input int rdy);
    bus.advance       = adv;
    bus.bubble        = bub;
    bus.flush         = fl;
    bus.exe_valid     = v;
    bus.exe_wr        = wr;
    bus.exe_dst       = REG_W'(dst);
    bus.exe_rdy_stage = SEL_W'(rdy);
    @(posedge clk);
    #1;
    bus.advance = 0; bus.bubble = 0; bus.flush = 0; bus.exe_valid = 0;
  endtask

  task automatic look(input int s0, input int s1);
    bus.exe_src = {REG_W'(s1), REG_W'(s0)};
    #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) begin
      bus.advance = 1'($urandom); bus.bubble = 1'($urandom); bus.flush = 1'($urandom);
      bus.exe_valid = 1'($urandom); bus.exe_wr = 1'($urandom);
      bus.exe_dst = REG_W'($urandom); bus.exe_rdy_stage = SEL_W'($urandom);
      bus.exe_src = (NUM_SRC*REG_W)'($urandom);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    look(1, 2);           chk3("reset", 0, 0, 0);

    // ALU producer r5 walks through all stages
    cyc(1, 0, 0, 1, 1, 5, 1);
    look(5, 0);           chk3("alu_s1", 4'b0001, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    look(5, 0);           chk3("alu_s3", 4'b0011, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    look(5, 0);           chk3("alu_gone", 0, 0, 0);

    // load-use: one stall, then bubble resolves it
    cyc(1, 0, 0, 1, 1, 7, 2);
    look(0, 7);           chk3("load_s1", 4'b0100, 2'b10, 1);
    cyc(0, 1, 0, 1, 1, 7, 2);
    look(0, 7);           chk3("load_bub", 4'b1000, 0, 0);

    // younger not-ready match wins over older ready one
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 3, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 3, 1);
    look(3, 0);           chk3("young_rdy", 4'b0001, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 3, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 3, 2);
    look(3, 3);           chk3("young_nrdy", 4'b0101, 2'b11, 1);

    // r0 and non-writing producers never match
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 1);
    look(0, 0);           chk3("r0", 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 4, 1);
    look(4, 0);           chk3("no_wr", 0, 0, 0);

    // rdy clamping and advance+bubble acting as advance
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 1, 8, 0);
    look(8, 0);           chk3("rdy0", 4'b0001, 0, 0);
    cyc(1, 0, 0, 1, 1, 8, 3);
    look(8, 0);           chk3("rdy3_s1", 4'b0001, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    look(8, 0);           chk3("rdy3_s2", 4'b0010, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    look(8, 0);           chk3("rdy3_s3", 4'b0011, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    look(8, 0);           chk3("hold", 4'b0011, 0, 0);

    // flush with advance drops everything, including the EXE instruction
    cyc(0, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 1, 1, 9, 1);
    look(9, 9);           chk3("r9_full", 4'b0101, 0, 0);
    cyc(1, 0, 1, 1, 1, 9, 1);
    look(9, 9);           chk3("flush_adv", 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    look(9, 9);           chk3("flush_after", 0, 0, 0);

    // reset mid-stream beats advance
    cyc(1, 0, 0, 1, 1, 6, 2);
    look(6, 0);           chk3("pre_rst", 4'b0001, 1, 1);
    rst = 1'b1;
    cyc(1, 0, 0, 1, 1, 6, 1);
    rst = 1'b0;
    look(6, 6);           chk3("mid_rst", 0, 0, 0);

    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised forwarding and load-use hazard unit for the EXE stage. It tracks every in-flight register write in a DEPTH-stage shift register, covering stage 1 (MEM) through stage DEPTH (WB). For each of NUM_SRC EXE source operands it selects the youngest matching producer. It raises a stall when that producer's data is not yet generated, for example a load still in MEM. It sits beside the EXE operand muxes and feeds the pipeline controller's stall/bubble logic.

## Interface
Parameters:
- NUM_SRC, 2, number of EXE source operands checked.
- DEPTH, 3, number of tracked producer stages after EXE (1=MEM, 2=MEM2, 3=WB).
- REG_W, 5, register index width.
- SEL_W, $clog2(DEPTH+1), width of one forward select / stage index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- exe_valid  in  1  EXE holds a real instruction.
- exe_wr  in  1  EXE instruction writes the register file.
- exe_dst  in  REG_W  EXE destination register.
- exe_rdy_stage  in  SEL_W  first stage index at which the EXE instruction's result exists (1 = ALU result, 2 = load data at MEM2); 0 is treated as 1, values >DEPTH are treated as DEPTH.
- exe_src  in  NUM_SRC*REG_W  EXE source registers; operand i is bits [i*REG_W +: REG_W].
- advance  in  1  pipeline moves; the EXE instruction enters stage 1.
- bubble  in  1  EXE is held; stages 1..DEPTH shift and an empty entry enters stage 1.
- flush  in  1  invalidate all tracked entries.
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = stage k result.
- src_stall  out  NUM_SRC  per-operand not-ready flag.
- stall  out  1  OR of src_stall.

## Operation
- State: per stage k in 1..DEPTH: valid_k, dst_k[REG_W], rdy_k[SEL_W].
- Entry insertion on advance: valid_1 = exe_valid & exe_wr & (exe_dst != 0); dst_1 = exe_dst; rdy_1 = exe_rdy_stage after clamping.
- Shift: on advance or bubble, stage k+1 takes stage k for k = 1..DEPTH-1. Stage DEPTH's old content is discarded.
- On bubble without advance, valid_1 = 0.
- Neither advance nor bubble: all entries hold.
- Priority of control inputs: rst > flush > advance > bubble.
  - flush clears every valid bit. There is no insertion that cycle, even if advance is high.
  - advance and bubble both high behaves as advance.
- Match for operand i at stage k: valid_k & (dst_k == src_i) & (src_i != 0).
- fwd_sel_i is the smallest k that matches (youngest producer), else 0.
- src_stall_i = 1 when the selected k satisfies k < rdy_k, i.e. data is not yet produced. fwd_sel_i still reports that k.
- An older ready match never overrides a younger not-ready match.
- Operands are evaluated independently; two operands naming the same register get identical results.
- fwd_sel, src_stall and stall are combinational from current state and exe_src. The block does not gate advance with stall; the pipeline controller must drive bubble instead of advance while stall = 1.

## Timing
- Reset: all valid bits clear on the first rising edge with rst = 1. From then on fwd_sel = 0, src_stall = 0, stall = 0.
- A producer is visible as stage 1 in the cycle after the edge that sampled advance.
- Zero-cycle lookup: outputs settle in the same cycle exe_src changes.
- A load with rdy = 2 followed by a dependent instruction produces exactly one stall cycle when DEPTH ≥ 2. In that cycle fwd_sel = 1 and stall = 1. After one bubble the entry is in stage 2, giving fwd_sel = 2 and stall = 0.
- Flush, including a flush asserted with advance or bubble, yields an empty scoreboard on the next cycle.
- Reset mid-stream overrides all inputs.
- Register 0 never matches, never stalls and is never inserted.

## Test plan
- Reset with random inputs, then exe_src = {r1, r2} → fwd_sel = 0, stall = 0.
- ALU producer r5 (rdy = 1), advance, then consumer src0 = r5 → fwd_sel0 = 1, stall = 0. After two more advances → fwd_sel0 = 3. After a fourth advance → 0.
- Load r7 (rdy = 2), advance, consumer src1 = r7 → fwd_sel1 = 1, src_stall = 2'b10, stall = 1. Bubble → fwd_sel1 = 2, stall = 0.
- r3 written in stage 1 (rdy = 1) and stage 3 → fwd_sel = 1. Same case with stage 1 rdy = 2 → fwd_sel = 1 and stall = 1; the older ready stage-3 copy is not used.
- Producer dst = 0 with exe_wr = 1, advance, consumer src = 0 → fwd_sel = 0, stall = 0. Producer with exe_wr = 0 → no match.
- Stages full of r9 producers, then flush together with advance → next cycle fwd_sel = 0 for src = r9, and the EXE instruction is not inserted.
